// File: rtl/bram_s9_s2_fifo_ctrl_pkg.sv
// Shared widths, the write-beat payload and the parity helper for the
// RAMB16_S2_S9 byte-in / dibit-out FIFO controller.
package bram_fifo_pkg;

    localparam int unsigned BYTE_AW     = 11;
    localparam int unsigned DIBIT_AW    = 13;
    localparam int unsigned DEPTH_BYTES = 2048;
    localparam int unsigned LEVEL_W     = 14;

    // One port-B write beat: data byte plus its parity bit.
    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } byte_beat_t;

    // Even parity bit for a byte (XOR of all data bits).
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/bram_s9_s2_fifo_ctrl_if.sv
// Producer/consumer handshake bundle of the dibit FIFO controller.
// The slave modport is the FIFO side, and the master modport is its user.
interface bram_s9_s2_fifo_ctrl_if;
    import bram_fifo_pkg::*;

    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [7:0]         wr_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [1:0]         rd_data;
    logic [LEVEL_W-1:0] level;
    logic               afull;

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level, afull
    );

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level, afull
    );

endinterface

// File: rtl/bram_s9_s2_fifo_ctrl_dibit_skid2.sv
// Two-entry dibit output buffer fed by the RAM read port.
// It presents its head on a valid/ready handshake.
module dibit_skid2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       load,
    input  logic [1:0] din,
    output logic       valid,
    input  logic       ready,
    output logic [1:0] dout,
    output logic [1:0] occ
);

    logic [1:0] head_q, tail_q, occ_q;
    logic [1:0] head_d, tail_d, occ_d;
    logic       pop;

    assign pop   = valid & ready;
    assign valid = (occ_q != 2'd0);
    assign dout  = head_q;
    assign occ   = occ_q;

    // The caller never loads a full buffer without also popping it.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            unique case ({load, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = din;
                    else               tail_d = din;
                    occ_d = 2'(occ_q + 2'd1);
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = 2'(occ_q - 2'd1);
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/bram_s9_s2_fifo_ctrl.sv
// FIFO controller owning both ports of a RAMB16_S2_S9. Bytes are written on port B
// (x9) and read back as LSB-first dibits on port A (x2) through a 2-entry buffer.
module bram_s9_s2_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned AFULL_BYTES = 2040
) (
    input  logic                CLK,
    input  logic                RST,
    bram_s9_s2_fifo_ctrl_if.slave fifo,

    output logic [DIBIT_AW-1:0] ADDRA,
    output logic                ENA,
    output logic                WEA,
    output logic [1:0]          DIA,
    output logic                SSRA,
    input  logic [1:0]          DOA,

    output logic [BYTE_AW-1:0]  ADDRB,
    output logic                ENB,
    output logic                WEB,
    output logic [7:0]          DIB,
    output logic                DIPB,
    output logic                SSRB
);

    localparam int unsigned PTR_W = $clog2(DEPTH_BYTES) + 1;

    logic [PTR_W-1:0]   wptr;
    logic [LEVEL_W-1:0] fptr;
    logic [LEVEL_W-1:0] cptr;
    logic               inflight;

    logic [PTR_W-1:0]   stored;
    logic [LEVEL_W-1:0] wdib;
    logic [LEVEL_W-1:0] fetchable;
    logic [1:0]         occ;
    logic [2:0]         buf_need;
    logic               push;
    logic               pop;
    logic               fetch;
    byte_beat_t         wbeat;

    // A slot is released only when all four of its dibits have been consumed.
    assign wdib      = {wptr, 2'b00};
    assign stored    = wptr - cptr[LEVEL_W-1:2];
    assign fetchable = wdib - fptr;

    assign fifo.wr_ready = ~stored[PTR_W-1];
    assign fifo.level    = wdib - cptr;
    assign fifo.afull    = (stored >= PTR_W'(AFULL_BYTES));

    // A push is dropped if flush arrives in the same cycle. It is also dropped
    // while RST is high, so port B stays idle during reset.
    assign push = fifo.wr_valid & fifo.wr_ready & ~fifo.flush & ~RST;
    assign pop  = fifo.rd_valid & fifo.rd_ready;

    // A fetch is issued only when the buffer is certain to have room when DOA lands.
    assign buf_need = 3'(occ) + 3'(inflight) - 3'(pop);
    assign fetch    = (fetchable != '0) && (buf_need < 3'd2) && !fifo.flush;

    always_comb begin
        wbeat = '0;
        if (push) begin
            wbeat.data = fifo.wr_data;
            wbeat.par  = even_par(fifo.wr_data);
        end
    end

    assign ENB   = push;
    assign WEB   = push;
    assign ADDRB = wptr[BYTE_AW-1:0];
    assign DIB   = wbeat.data;
    assign DIPB  = wbeat.par;
    assign SSRB  = 1'b0;

    assign ENA   = fetch;
    assign ADDRA = fptr[DIBIT_AW-1:0];
    assign WEA   = 1'b0;
    assign DIA   = '0;
    assign SSRA  = 1'b0;

    // Clearing inflight on flush makes the buffer ignore the DOA still in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            fptr     <= '0;
            cptr     <= '0;
            inflight <= 1'b0;
        end else if (fifo.flush) begin
            wptr     <= '0;
            fptr     <= '0;
            cptr     <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wptr <= wptr + PTR_W'(1);
            if (fetch) fptr <= fptr + LEVEL_W'(1);
            if (pop)   cptr <= cptr + LEVEL_W'(1);
            inflight <= fetch;
        end
    end

    dibit_skid2 u_skid (
        .clk   (CLK),
        .rst   (RST),
        .flush (fifo.flush),
        .load  (inflight),
        .din   (DOA),
        .valid (fifo.rd_valid),
        .ready (fifo.rd_ready),
        .dout  (fifo.rd_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_bram_s9_s2_fifo_ctrl.sv
// Bench for bram_s9_s2_fifo_ctrl with a behavioural RAMB16_S2_S9 model
// and a dibit scoreboard.
module tb_bram_s9_s2_fifo_ctrl;
    import bram_fifo_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bram_s9_s2_fifo_ctrl_if fifo_if ();

    logic [DIBIT_AW-1:0] ADDRA;
    logic                ENA, WEA, SSRA;
    logic [1:0]          DIA;
    logic [1:0]          DOA;
    logic [BYTE_AW-1:0]  ADDRB;
    logic                ENB, WEB, DIPB, SSRB;
    logic [7:0]          DIB;

    bram_s9_s2_fifo_ctrl #(.AFULL_BYTES(2040)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .fifo  (fifo_if),
        .ADDRA (ADDRA),
        .ENA   (ENA),
        .WEA   (WEA),
        .DIA   (DIA),
        .SSRA  (SSRA),
        .DOA   (DOA),
        .ADDRB (ADDRB),
        .ENB   (ENB),
        .WEB   (WEB),
        .DIB   (DIB),
        .DIPB  (DIPB),
        .SSRB  (SSRB)
    );

    // RAMB16_S2_S9 model: port A address 4b+k returns bits [2k+1:2k] of byte b.
    logic [7:0] mem [DEPTH_BYTES];
    always @(posedge CLK) begin
        if (ENB && WEB) mem[ADDRB] <= DIB;
        if (ENA) DOA <= 2'(mem[ADDRA[DIBIT_AW-1:2]] >> {ADDRA[1:0], 1'b0});
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: accepted bytes expand to four dibits, LSB first.
    logic [1:0] sb_q [$];
    logic       sb_en  = 1'b0;
    logic       bub_en = 1'b0;
    logic       seen   = 1'b0;
    int         bubbles = 0;
    int         popped  = 0;

    always @(negedge CLK) begin
        if (RST || fifo_if.flush) begin
            sb_q.delete();
        end else if (sb_en) begin
            if (fifo_if.rd_valid && fifo_if.rd_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_pop", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("sb_dibit", 32'(fifo_if.rd_data), 32'(sb_q.pop_front()));
                    popped++;
                end
            end
            if (fifo_if.wr_valid && fifo_if.wr_ready) begin
                chk("sb_dib", 32'(DIB), 32'(fifo_if.wr_data));
                chk("sb_dipb", 32'(DIPB), 32'(^fifo_if.wr_data));
                for (int k = 0; k < 4; k++) sb_q.push_back(2'(fifo_if.wr_data >> (2 * k)));
            end
        end
        if (bub_en) begin
            if (fifo_if.rd_valid) seen = 1'b1;
            else if (seen && fifo_if.level != '0) bubbles++;
        end
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((fifo_if.level != '0 || fifo_if.rd_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(fifo_if.level == '0 && !fifo_if.rd_valid), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_ready"}, 32'(fifo_if.wr_ready), 32'd1);
        chk({tag, "_rd_valid"}, 32'(fifo_if.rd_valid), 32'd0);
        chk({tag, "_rd_data"},  32'(fifo_if.rd_data),  32'd0);
        chk({tag, "_level"},    32'(fifo_if.level),    32'd0);
        chk({tag, "_afull"},    32'(fifo_if.afull),    32'd0);
        chk({tag, "_ena"},      32'(ENA),   32'd0);
        chk({tag, "_addra"},    32'(ADDRA), 32'd0);
        chk({tag, "_enb"},      32'(ENB),   32'd0);
        chk({tag, "_web"},      32'(WEB),   32'd0);
        chk({tag, "_addrb"},    32'(ADDRB), 32'd0);
        chk({tag, "_dib"},      32'(DIB),   32'd0);
        chk({tag, "_dipb"},     32'(DIPB),  32'd0);
        chk({tag, "_ties"},     32'({WEA, DIA, SSRA, SSRB}), 32'd0);
    endtask

    typedef struct {
        logic        wv;
        logic [7:0]  wd;
        logic        rr;
        logic        rv;
        logic        crd;
        logic [1:0]  rd;
        logic [13:0] lvl;
        logic        ena;
        logic [12:0] adra;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                                input logic rv, input logic crd, input logic [1:0] rd,
                                input logic [13:0] lvl, input logic ena, input logic [12:0] adra);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.rv = rv; v.crd = crd;
        v.rd = rd; v.lvl = lvl; v.ena = ena; v.adra = adra;
        return v;
    endfunction

    initial begin
        vec_t       vt [9];
        logic [1:0] got [4];
        int         ngot;
        int         n;
        int         pushed;
        logic [7:0] fb;

        // Single push of 0xE4 from reset: the fetch pipeline, then four pops.
        vt[0] = mk(1'b1, 8'hE4, 1'b0, 1'b0, 1'b1, 2'd0, 14'd0, 1'b0, 13'd0);
        vt[1] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 14'd4, 1'b1, 13'd0);
        vt[2] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 14'd4, 1'b1, 13'd1);
        vt[3] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 14'd4, 1'b0, 13'd0);
        vt[4] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 14'd4, 1'b1, 13'd2);
        vt[5] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 14'd3, 1'b1, 13'd3);
        vt[6] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 14'd2, 1'b0, 13'd0);
        vt[7] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd3, 14'd1, 1'b0, 13'd0);
        vt[8] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 14'd0, 1'b0, 13'd0);

        RST = 1'b1;
        fifo_if.flush    = 1'b0;
        fifo_if.wr_valid = 1'b1;
        fifo_if.wr_data  = 8'hA5;
        fifo_if.rd_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk_reset_vals("reset");
        fifo_if.wr_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 9; i++) begin
            fifo_if.wr_valid = vt[i].wv;
            fifo_if.wr_data  = vt[i].wd;
            fifo_if.rd_ready = vt[i].rr;
            #1;
            chk($sformatf("v%0d_wr_ready", i), 32'(fifo_if.wr_ready), 32'd1);
            chk($sformatf("v%0d_rd_valid", i), 32'(fifo_if.rd_valid), 32'(vt[i].rv));
            if (vt[i].crd) chk($sformatf("v%0d_rd_data", i), 32'(fifo_if.rd_data), 32'(vt[i].rd));
            chk($sformatf("v%0d_level", i), 32'(fifo_if.level), 32'(vt[i].lvl));
            chk($sformatf("v%0d_enb", i), 32'(ENB), 32'(vt[i].wv));
            chk($sformatf("v%0d_dib", i), 32'(DIB), vt[i].wv ? 32'(vt[i].wd) : 32'd0);
            chk($sformatf("v%0d_dipb", i), 32'(DIPB), 32'(vt[i].wv & (^vt[i].wd)));
            chk($sformatf("v%0d_ena", i), 32'(ENA), 32'(vt[i].ena));
            if (vt[i].ena) chk($sformatf("v%0d_addra", i), 32'(ADDRA), 32'(vt[i].adra));
            tick();
        end

        // Continuous stream 0x00..0xFF with the consumer always ready.
        sb_en = 1'b1; bub_en = 1'b1; seen = 1'b0; bubbles = 0; popped = 0;
        fifo_if.rd_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            fifo_if.wr_valid = 1'b1;
            fifo_if.wr_data  = 8'(i);
            tick();
        end
        fifo_if.wr_valid = 1'b0;
        drain("stream_drain", 2000);
        bub_en = 1'b0;
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_count", 32'(popped), 32'd1024);

        // Fill all 2048 bytes with the consumer stalled.
        fifo_if.rd_ready = 1'b0;
        popped = 0;
        for (int k = 0; k < 2048; k++) begin
            fifo_if.wr_valid = 1'b1;
            fifo_if.wr_data  = 8'(k * 7 + 3);
            #1;
            if (k == 2039) chk("afull_below", 32'(fifo_if.afull), 32'd0);
            if (k == 2040) chk("afull_at", 32'(fifo_if.afull), 32'd1);
            if (k == 2047) chk("ready_last_slot", 32'(fifo_if.wr_ready), 32'd1);
            tick();
        end
        fifo_if.wr_data = 8'hEE;
        #1;
        chk("full_wr_ready", 32'(fifo_if.wr_ready), 32'd0);
        chk("full_enb", 32'(ENB), 32'd0);
        chk("full_level", 32'(fifo_if.level), 32'd8192);
        chk("full_afull", 32'(fifo_if.afull), 32'd1);
        chk("full_rd_valid", 32'(fifo_if.rd_valid), 32'd1);
        fifo_if.wr_valid = 1'b0;
        fifo_if.rd_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk($sformatf("full_pop%0d_wr_ready", p + 1), 32'(fifo_if.wr_ready), 32'd0);
        end
        fifo_if.wr_valid = 1'b1;
        fifo_if.wr_data  = 8'hC3;
        #1;
        chk("full_pushpop_enb", 32'(ENB), 32'd0);
        chk("full_pushpop_rd_valid", 32'(fifo_if.rd_valid), 32'd1);
        tick();
        fifo_if.wr_valid = 1'b0;
        chk("ready_after_4th_pop", 32'(fifo_if.wr_ready), 32'd1);
        chk("level_after_4th_pop", 32'(fifo_if.level), 32'd8188);
        drain("full_drain", 9000);
        chk("full_count", 32'(popped), 32'd8192);
        chk("full_sb_empty", 32'(sb_q.size()), 32'd0);

        // Three full passes with random valid/ready patterns.
        popped = 0; pushed = 0; n = 0;
        while ((pushed < 6144 || fifo_if.level != '0 || fifo_if.rd_valid) && n < 60000) begin
            fifo_if.wr_valid = (pushed < 6144) && ($urandom_range(0, 9) < 7);
            fifo_if.wr_data  = 8'($urandom);
            fifo_if.rd_ready = ($urandom_range(0, 9) < 8);
            #1;
            if (fifo_if.wr_valid && fifo_if.wr_ready) pushed++;
            tick();
            n++;
        end
        fifo_if.wr_valid = 1'b0;
        chk("rand_finished", 32'(n < 60000), 32'd1);
        chk("rand_count", 32'(popped), 32'd24576);
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);

        // Flush with data buffered and a fetch in flight.
        sb_en = 1'b0;
        fifo_if.rd_ready = 1'b0;
        fifo_if.wr_valid = 1'b1;
        fifo_if.wr_data  = 8'hFF;
        tick();
        fifo_if.wr_valid = 1'b0;
        tick();
        tick();
        chk("preflush_rd_valid", 32'(fifo_if.rd_valid), 32'd1);
        chk("preflush_level", 32'(fifo_if.level), 32'd4);
        fifo_if.flush = 1'b1;
        tick();
        fifo_if.flush = 1'b0;
        chk("flush_rd_valid", 32'(fifo_if.rd_valid), 32'd0);
        chk("flush_level", 32'(fifo_if.level), 32'd0);
        chk("flush_wr_ready", 32'(fifo_if.wr_ready), 32'd1);
        tick();
        chk("flush_stale_dropped", 32'(fifo_if.rd_valid), 32'd0);
        fifo_if.wr_valid = 1'b1;
        fifo_if.wr_data  = 8'h1B;
        #1;
        chk("post_flush_addrb", 32'(ADDRB), 32'd0);
        chk("post_flush_dipb", 32'(DIPB), 32'd0);
        tick();
        fifo_if.wr_valid = 1'b0;
        fifo_if.rd_ready = 1'b1;
        ngot = 0; n = 0;
        while (ngot < 4 && n < 20) begin
            if (fifo_if.rd_valid) begin
                got[ngot] = fifo_if.rd_data;
                ngot++;
            end
            tick();
            n++;
        end
        chk("post_flush_count", 32'(ngot), 32'd4);
        fb = 8'h1B;
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_flush_d%0d", k), 32'(got[k]), 32'(2'(fb >> (2 * k))));
        chk("post_flush_empty", 32'(fifo_if.level), 32'd0);

        // Asynchronous reset in the middle of a stream.
        sb_en = 1'b1;
        fifo_if.rd_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            fifo_if.wr_valid = 1'b1;
            fifo_if.wr_data  = 8'(8'h30 + i);
            if (i < 20) tick();
        end
        #2;
        RST = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        fifo_if.wr_valid = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        popped = 0;
        for (int i = 0; i < 40; i++) begin
            fifo_if.wr_valid = 1'b1;
            fifo_if.wr_data  = 8'(8'h9C ^ (i * 13));
            tick();
        end
        fifo_if.wr_valid = 1'b0;
        drain("resume_drain", 400);
        chk("resume_count", 32'(popped), 32'd160);
        chk("resume_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
